// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int DEBOUNCE_SAMPLES_DEF = 8;
  localparam int BLINK_TICKS_DEF      = 250;

  // Button slots inside the packed button vector.
  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;
  localparam int NUM_BTN = 3;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Single push-button conditioner: 2-FF synchronizer, tick-sampled history,
// hysteretic debounced level and a one-clock press pulse on its rising edge.
module button_debounce #(
  parameter int SAMPLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0]         sync_q;
  logic [SAMPLES-1:0] hist_q, hist_d;
  logic               level_q, level_d;
  logic               press_q;

  // Next history and level: level only moves once the whole window agrees.
  always_comb begin
    hist_d  = hist_q;
    if (sample_tick) hist_d = {hist_q[SAMPLES-2:0], sync_q[1]};
    level_d = level_q;
    if (&hist_d)       level_d = 1'b1;
    else if (~|hist_d) level_d = 1'b0;
  end

  // Registers; the press pulse is taken from the next level so it appears
  // one clock after the completing sample_tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      hist_q  <= hist_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive a 4-state FSM that enables /
// clears the seconds counter, latches lap values and blinks while paused.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF,
  parameter int BLINK_TICKS      = BLINK_TICKS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [31:0] live_count,
  output logic        count_enable,
  output logic        count_clear,
  output logic [31:0] display_value,
  output logic [7:0]  blank_mask,
  output logic [1:0]  state
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [NUM_BTN-1:0] btn_raw, press;
  logic               evt_clr, evt_ss, evt_lap;

  sw_state_t   state_q, state_d;
  logic        en_q, clr_q, clr_d;
  logic [31:0] lap_q, lap_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  assign btn_raw[BTN_SS]  = btn_start_stop;
  assign btn_raw[BTN_LAP] = btn_lap;
  assign btn_raw[BTN_CLR] = btn_clear;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    button_debounce #(.SAMPLES(DEBOUNCE_SAMPLES)) u_db (
      .clock       (clock),
      .reset       (reset),
      .sample_tick (sample_tick),
      .btn_i       (btn_raw[b]),
      .press_o     (press[b])
    );
  end

  // Only the highest-priority event of a cycle survives.
  assign evt_clr = press[BTN_CLR];
  assign evt_ss  = press[BTN_SS]  & ~evt_clr;
  assign evt_lap = press[BTN_LAP] & ~evt_clr & ~press[BTN_SS];

  // Next-state, clear pulse and lap capture.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    lap_d   = lap_q;
    case (state_q)
      IDLE: begin
        if (evt_clr)     clr_d   = 1'b1;
        else if (evt_ss) state_d = RUN;
      end
      RUN: begin
        if (evt_ss) state_d = PAUSE;
        else if (evt_lap) begin
          state_d = LAP;
          lap_d   = live_count;
        end
      end
      LAP: begin
        if (evt_lap)     state_d = RUN;
        else if (evt_ss) state_d = PAUSE;
      end
      PAUSE: begin
        if (evt_clr) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (evt_ss) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink counter runs only while staying in PAUSE; zero everywhere else,
  // which also gives a fresh phase on every entry into PAUSE.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (state_q == PAUSE && state_d == PAUSE) begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (sample_tick) begin
        if (cnt_q == BLINK_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      lap_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == RUN) || (state_d == LAP);
      clr_q   <= clr_d;
      lap_q   <= lap_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign count_enable  = en_q;
  assign count_clear   = clr_q;
  assign state         = state_q;
  assign display_value = (state_q == LAP) ? lap_q : live_count;
  assign blank_mask    = (state_q == PAUSE) ? {8{phase_q}} : 8'h00;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: expected FSM states are queued as buttons are
// driven and popped by a monitor whenever the DUT state output changes.
module tb_stopwatch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [2:0]  btns = 3'b000;   // {clear, lap, start_stop}
  logic [31:0] live_count = 32'h12;
  logic        count_enable, count_clear;
  logic [31:0] display_value;
  logic [7:0]  blank_mask;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;
  int tcnt  = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_state = 2'd0;
  int clr_run = 0;
  int clr_pulses = 0;

  localparam logic [2:0] B_SS = 3'b001, B_LAP = 3'b010, B_CLR = 3'b100;

  stopwatch_ctrl #(.DEBOUNCE_SAMPLES(4), .BLINK_TICKS(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .sample_tick    (sample_tick),
    .btn_start_stop (btns[0]),
    .btn_lap        (btns[1]),
    .btn_clear      (btns[2]),
    .live_count     (live_count),
    .count_enable   (count_enable),
    .count_clear    (count_clear),
    .display_value  (display_value),
    .blank_mask     (blank_mask),
    .state          (state)
  );

  always #5 clock = ~clock;

  // sample_tick: one cycle in every ten, changed just after the edge.
  always begin
    @(posedge clock);
    #1;
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    sample_tick = (tcnt == 9);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Returns on the edge where the DUT samples the n-th next tick.
  task automatic wait_tick(input int n);
    repeat (n) begin
      @(posedge clock);
      while (!sample_tick) @(posedge clock);
    end
  endtask

  task automatic press(input logic [2:0] b);
    btns = btns | b;
    wait_tick(5);
    #1 btns = btns & ~b;
    wait_tick(5);
    #1;
  endtask

  // Scoreboard monitor: state changes and count_clear pulse shape.
  always @(negedge clock) begin
    if (state !== prev_state) begin
      if (exp_q.size() == 0) chk("st_unexpected", {30'd0, state}, {30'd0, prev_state});
      else                   chk("st_seq", {30'd0, state}, {30'd0, exp_q.pop_front()});
      prev_state = state;
    end
    if (count_clear) begin
      clr_run++;
      chk("clr_state", {30'd0, state}, 32'd0);
    end else begin
      if (clr_run != 0) begin
        chk("clr_width", clr_run, 1);
        clr_pulses++;
      end
      clr_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_en", {31'd0, count_enable}, 32'd0);
    chk("rst_mask", {24'd0, blank_mask}, 32'd0);
    reset = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    chk("idle_state", {30'd0, state}, 32'd0);
    chk("idle_en", {31'd0, count_enable}, 32'd0);
    chk("idle_clr", {31'd0, count_clear}, 32'd0);
    chk("idle_mask", {24'd0, blank_mask}, 32'd0);
    chk("idle_disp", display_value, 32'h12);

    // Start with bounce: samples 1,0,1,1,1,1 -> event after 6th tick
    exp_q.push_back(2'd1);
    btns[0] = 1'b1;
    wait_tick(1); #1 btns[0] = 1'b0;
    wait_tick(1); #1 btns[0] = 1'b1;
    wait_tick(3); #1;
    chk("bounce_hold", {30'd0, state}, 32'd0);
    wait_tick(1); #1;
    chk("start_lat0", {30'd0, state}, 32'd0);
    @(posedge clock); #1;
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_en", {31'd0, count_enable}, 32'd1);
    wait_tick(5); #1;
    chk("start_held", {30'd0, state}, 32'd1);
    btns[0] = 1'b0;
    wait_tick(5); #1;

    // Lap capture and release
    live_count = 32'h42;
    exp_q.push_back(2'd3);
    press(B_LAP);
    chk("lap_disp", display_value, 32'h42);
    live_count = 32'h50;
    #1 chk("lap_hold", display_value, 32'h42);
    chk("lap_en", {31'd0, count_enable}, 32'd1);
    exp_q.push_back(2'd1);
    press(B_LAP);
    chk("unlap_disp", display_value, 32'h50);

    // Pause and blink
    exp_q.push_back(2'd2);
    btns[0] = 1'b1;
    wait_tick(4);
    @(posedge clock); #1;
    chk("pause_state", {30'd0, state}, 32'd2);
    chk("pause_en", {31'd0, count_enable}, 32'd0);
    chk("blink0", {24'd0, blank_mask}, 32'h00);
    wait_tick(2); #1;
    chk("blink2", {24'd0, blank_mask}, 32'h00);
    wait_tick(1); #1;
    chk("blink3", {24'd0, blank_mask}, 32'hFF);
    btns[0] = 1'b0;
    wait_tick(2); #1;
    chk("blink5", {24'd0, blank_mask}, 32'hFF);
    wait_tick(1); #1;
    chk("blink6", {24'd0, blank_mask}, 32'h00);
    wait_tick(4); #1;

    // Clear from PAUSE, then clear in IDLE
    exp_q.push_back(2'd0);
    press(B_CLR);
    chk("clr_mask", {24'd0, blank_mask}, 32'h00);
    chk("clr_cnt1", clr_pulses, 1);
    press(B_CLR);
    chk("idle_clr_cnt", clr_pulses, 2);

    // Simultaneous clear + start_stop in RUN: clear wins, ignored
    exp_q.push_back(2'd1);
    press(B_SS);
    press(B_CLR | B_SS);
    chk("run_both_state", {30'd0, state}, 32'd1);
    chk("run_both_clr", clr_pulses, 2);

    // Simultaneous in PAUSE: clear to IDLE
    exp_q.push_back(2'd2);
    press(B_SS);
    exp_q.push_back(2'd0);
    press(B_CLR | B_SS);
    chk("pause_both_clr", clr_pulses, 3);

    // Async reset from LAP with buttons held through it
    exp_q.push_back(2'd1);
    press(B_SS);
    live_count = 32'h77;
    exp_q.push_back(2'd3);
    press(B_LAP);
    chk("lap2_disp", display_value, 32'h77);
    exp_q.push_back(2'd0);
    btns = B_SS | B_LAP;
    #3 reset = 1'b0;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_en", {31'd0, count_enable}, 32'd0);
    chk("arst_disp", display_value, 32'h77);
    wait_tick(1);
    #3 reset = 1'b1;
    exp_q.push_back(2'd1);   // start_stop outranks lap on the same tick
    wait_tick(3); #1;
    chk("post_rst_hold", {30'd0, state}, 32'd0);
    wait_tick(1);
    @(posedge clock); #1;
    chk("post_rst_state", {30'd0, state}, 32'd1);
    chk("post_rst_en", {31'd0, count_enable}, 32'd1);
    btns = 3'b000;
    wait_tick(5); #1;

    chk("q_empty", exp_q.size(), 0);
    chk("clr_total", clr_pulses, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
